// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor (A - B), one bit per clock,
// LSB first, driving a single shared one-bit full_sub cell. Operands are
// latched on an accepted start; the result is reported via busy/done.

// One-bit full subtractor: o_diff = a - b - b_in, o_b_out = borrow out.
module full_sub (
  input  logic i_a,
  input  logic i_b,
  input  logic i_b_in,
  output logic o_diff,
  output logic o_b_out
);

  // Difference is odd parity; borrow when b (plus incoming borrow) exceeds a.
  always_comb begin
    o_diff  = i_a ^ i_b ^ i_b_in;
    o_b_out = (~i_a & i_b) | (~(i_a ^ i_b) & i_b_in);
  end

endmodule

module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_bit_diff;
  logic             w_bit_bout;

  // Shared one-bit cell fed from the low bits of the operand shifters.
  full_sub u_full_sub (
    .i_a     (r_a_sh[0]),
    .i_b     (r_b_sh[0]),
    .i_b_in  (r_br),
    .o_diff  (w_bit_diff),
    .o_b_out (w_bit_bout)
  );

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Start is not queued here; a held start is taken in IDLE.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Operand shifters, borrow chain, bit counter and result registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      // diff/borrow hold the previous result until the first RUN edge.
      r_a_sh <= i_a;
      r_b_sh <= i_b;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_shift) begin
      r_diff <= {w_bit_diff, r_diff[WIDTH-1:1]};
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_br   <= w_bit_bout;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_borrow <= w_bit_bout;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed + random bench for serial_sub_ctrl at WIDTH=8 and WIDTH=4.
// Expected results are queued at start and checked when done pulses.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s8, s4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       bz8, dn8, bo8;
  logic       bz4, dn4, bo4;
  logic [7:0] df8;
  logic [3:0] df4;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .i_a(a8), .i_b(b8),
    .o_busy(bz8), .o_done(dn8), .o_diff(df8), .o_borrow(bo8)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .i_a(a4), .i_b(b4),
    .o_busy(bz4), .o_done(dn4), .o_diff(df4), .o_borrow(bo4)
  );

  typedef struct {
    logic [31:0] d;
    logic        br;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular subtraction and unsigned compare.
  task automatic push_exp(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    exp_t        e;
    mask = (32'(1) << w) - 32'(1);
    e.d  = (a - b) & mask;
    e.br = ((a & mask) < (b & mask));
    if (w == 8) q8.push_back(e);
    else        q4.push_back(e);
  endtask

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin
    if (dn8) begin
      exp_t e;
      chk("q8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("diff8", 32'(df8), e.d);
        chk("borrow8", 32'(bo8), 32'(e.br));
      end
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (dn4) begin
      exp_t e;
      chk("q4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("diff4", 32'(df4), e.d);
        chk("borrow4", 32'(bo4), 32'(e.br));
      end
    end
  end

  // One start pulse; waits a fixed 14 cycles, reporting done position and busy length.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        output int done_at, output int busy_n);
    done_at = 0;
    busy_n  = 0;
    push_exp(w, a, b);
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; s8 = 1'b1; end
    else        begin a4 = a[3:0]; b4 = b[3:0]; s4 = 1'b1; end
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 1) begin s8 = 1'b0; s4 = 1'b0; end
      if (w == 8) begin
        if (dn8 && done_at == 0) done_at = j;
        if (bz8) busy_n++;
      end else begin
        if (dn4 && done_at == 0) done_at = j;
        if (bz4) busy_n++;
      end
    end
  endtask

  logic [7:0] edge_a [3] = '{8'h00, 8'hFF, 8'h80};
  logic [7:0] edge_b [3] = '{8'h01, 8'hFF, 8'h7F};

  initial begin
    int da, bn, ndone, first, second;
    rst_n = 1'b0;
    s8 = 1'b0; s4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy8", 32'(bz8), 32'd0);
    chk("rst_done8", 32'(dn8), 32'd0);
    chk("rst_diff8", 32'(df8), 32'd0);
    chk("rst_borrow8", 32'(bo8), 32'd0);
    chk("rst_busy4", 32'(bz4), 32'd0);
    chk("rst_diff4", 32'(df4), 32'd0);

    // Basic subtraction, latency and busy length.
    run_op(8, 32'h5A, 32'h23, da, bn);
    chk("basic_done_at", 32'(da), 32'd9);
    chk("basic_busy_cycles", 32'(bn), 32'd9);
    chk("hold_diff", 32'(df8), 32'h37);
    chk("hold_borrow", 32'(bo8), 32'd0);

    // Wrap-around and edge operands.
    for (int i = 0; i < 3; i++) begin
      run_op(8, 32'(edge_a[i]), 32'(edge_b[i]), da, bn);
      chk("edge_done_at", 32'(da), 32'd9);
    end

    // Start pulsed with new operands mid-RUN is ignored.
    push_exp(8, 32'h5A, 32'h23);
    a8 = 8'h5A; b8 = 8'h23; s8 = 1'b1;
    ndone = 0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == 1) s8 = 1'b0;
      if (j == 3) begin s8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
      if (j == 4) s8 = 1'b0;
      if (dn8) ndone++;
    end
    chk("ignored_done_count", 32'(ndone), 32'd1);

    // Start held through DONE restarts on the first IDLE edge.
    push_exp(8, 32'h5A, 32'h23);
    push_exp(8, 32'h5A, 32'h23);
    a8 = 8'h5A; b8 = 8'h23; s8 = 1'b1;
    first = 0; second = 0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (j == 10) chk("held_idle_gap", 32'(bz8), 32'd0);
      if (j == 11) s8 = 1'b0;
      if (dn8) begin
        if (first == 0) first = j;
        else if (second == 0) second = j;
      end
    end
    chk("held_first_done", 32'(first), 32'd9);
    chk("held_interval", 32'(second - first), 32'd10);

    // Reset mid-RUN aborts without done.
    a8 = 8'hC3; b8 = 8'h3C; s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bz8), 32'd0);
    chk("abort_done", 32'(dn8), 32'd0);
    chk("abort_diff", 32'(df8), 32'd0);
    chk("abort_borrow", 32'(bo8), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn8) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8, 32'h10, 32'h01, da, bn);
    chk("post_abort_done_at", 32'(da), 32'd9);

    // Random operands at both widths.
    for (int i = 0; i < 500; i++) begin
      run_op(8, $urandom, $urandom, da, bn);
      chk("rand8_done_at", 32'(da), 32'd9);
    end
    for (int i = 0; i < 500; i++) begin
      run_op(4, $urandom, $urandom, da, bn);
      chk("rand4_done_at", 32'(da), 32'd5);
      chk("rand4_busy_cycles", 32'(bn), 32'd5);
    end

    repeat (2) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller that computes A − B with a single instance of the one-bit `full_sub` cell, one bit per clock, LSB first. It latches the operands and sequences the cell over WIDTH cycles. It carries the borrow between bit slices in a register and reports the result through a start/busy/done handshake. It sits between a requester that wants an occasional WIDTH-bit difference and the shared one-bit subtractor datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  minuend; sampled on the accepting edge only
- b  input  WIDTH  subtrahend; sampled on the accepting edge only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse in DONE
- diff  output  WIDTH  result A − B modulo 2^WIDTH
- borrow  output  1  final borrow out; 1 iff A < B unsigned

## Operation
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - diff: result shift register.
  - br: running borrow.
  - cnt: ceil(log2(WIDTH))-bit bit index.
  - state: IDLE, RUN or DONE.
- full_sub wiring:
  - a = a_sh[0], b = b_sh[0], b_in = br.
  - difference and b_out feed the registers below.
- IDLE:
  - On start=1: a_sh←a, b_sh←b, br←0, cnt←0, state←RUN.
  - diff and borrow keep their previous values until the first RUN edge.
- RUN, on each edge:
  - diff ← {difference, diff[WIDTH-1:1]} (result shifts in from the MSB side).
  - a_sh and b_sh shift right by one.
  - br ← b_out.
  - cnt ← cnt+1.
  - When cnt = WIDTH−1: state←DONE and borrow ← b_out.
- DONE: done=1 for exactly one cycle, then state←IDLE unconditionally.
- Result hold: diff and borrow stay stable from the DONE cycle until the next accepted start has its first RUN edge.
- start is ignored (not queued) in RUN and DONE. A start held high through DONE is accepted on the first IDLE edge.
- a and b changing while busy has no effect.
- Reset (rst_n=0 on any edge, including mid-RUN):
  - state←IDLE, cnt←0, br←0.
  - diff←0, borrow←0, a_sh←0, b_sh←0.
  - busy=0, done=0 from the next cycle.
  - An aborted operation never asserts done.
- Reset has priority over start on the same edge.

## Timing
- Output values after reset: busy=0, done=0, diff=0, borrow=0.
- busy and done decode directly from the state register (no combinational path from start).
- Start accepted at edge k:
  - busy=1 from edge k through edge k+WIDTH+1.
  - RUN covers edges k+1 … k+WIDTH, each edge retiring one bit.
  - DONE is the cycle between edges k+WIDTH and k+WIDTH+1: done=1, with diff and borrow already final.
  - busy=0 and state=IDLE after edge k+WIDTH+1.
- Latency from start edge to done cycle: WIDTH cycles. Minimum issue interval: WIDTH+2 cycles.
- Borrow chain: bit i uses the borrow from bit i−1 registered one cycle earlier. No combinational carry chain across bits.

## Test plan
- Reset state: hold rst_n=0 for 2 cycles, then release -> busy=0, done=0, diff=0x00, borrow=0.
- Basic subtraction: WIDTH=8, a=0x5A, b=0x23, start pulse -> done exactly 8 cycles after the start edge, diff=0x37, borrow=0; busy high 9 cycles.
- Wrap-around and edge operands:
  - a=0x00, b=0x01 -> diff=0xFF, borrow=1.
  - a=0xFF, b=0xFF -> diff=0x00, borrow=0.
  - a=0x80, b=0x7F -> diff=0x01, borrow=0.
- Start ignored while busy: pulse start with new operands 3 cycles into RUN -> result unchanged (0x37 case), done pulses once. Holding start through DONE -> second operation starts on the IDLE edge, exactly WIDTH+2 cycles after the first.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN -> next cycle busy=0, diff=0, borrow=0, no done. A fresh start afterwards (0x10 − 0x01) -> diff=0x0F.
- Randomized check, WIDTH=8 and WIDTH=4: 500 random a,b pairs -> diff == (a−b) mod 2^WIDTH and borrow == (a<b) for every transaction.
